// File: rtl/dart_hit_capture.sv
// Dart hit capture: edge-detects the impact sensor strobe, buffers hit coordinates in a
// small FIFO and hands them one at a time to the scoring machine. The scoring machine
// answers each dart with a player done pulse. An optional hold-off gap follows each done
// pulse. game_set_i freezes the block in STOP until reset.
//
// Optional feature: define DART_RANGE_CHECK_EN to reject hits with x>9 or y>9. Rejected
// hits are counted on drop_count_o, which is present only in that build.
//
// Ports:
//   clk, reset                          rising-edge clock, synchronous active-low reset
//   hit_strobe_i, hit_x_i, hit_y_i      sensor strobe (rising edge = hit) and coordinates
//   player_1_done_i, player_2_done_i    turn-end pulses, honoured only while waiting
//   game_set_i                          game over: go to STOP and flush the FIFO
//   dart_come_o                         one-cycle dart-arrival pulse
//   dart_position_x_o/y_o               coordinates of the most recently issued dart
//   fifo_count_o                        buffered hits
//   overflow_o                          sticky: a hit was lost to a full FIFO
//   drop_count_o                        saturating count of out-of-range hits (optional)
//   busy_o                              a dart is outstanding (ISSUE, WAIT, HOLD)
module dart_hit_capture #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HOLDOFF    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hit_strobe_i,
  input  logic [3:0] hit_x_i,
  input  logic [3:0] hit_y_i,
  input  logic       player_1_done_i,
  input  logic       player_2_done_i,
  input  logic       game_set_i,
  output logic       dart_come_o,
  output logic [3:0] dart_position_x_o,
  output logic [3:0] dart_position_y_o,
  output logic [3:0] fifo_count_o,
  output logic       overflow_o,
`ifdef DART_RANGE_CHECK_EN
  output logic [7:0] drop_count_o,
`endif
  output logic       busy_o
);

  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  DepthC   = 4'(FIFO_DEPTH);
  localparam logic [3:0]  HoldLast = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StHold, StStop} state_e;

  state_e            state_q, state_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic              strobe_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [3:0]        count_q;
  logic              overflow_q;
  logic [3:0]        pos_x_q, pos_y_q;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic hit, in_range, push_req, push, pop, drop, full, empty, done, flush;

  assign hit   = hit_strobe_i & ~strobe_q;
  assign full  = (count_q == DepthC);
  assign empty = (count_q == 4'd0);
  assign done  = player_1_done_i | player_2_done_i;
  assign flush = game_set_i | (state_q == StStop);

`ifdef DART_RANGE_CHECK_EN
  logic [7:0] drop_cnt_q;
  assign in_range     = (hit_x_i <= 4'd9) && (hit_y_i <= 4'd9);
  assign drop_count_o = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_q <= 8'd0;
    end else if (hit && !in_range && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end
`else
  assign in_range = 1'b1;
`endif

  // A pop in the same cycle frees a slot, so a full FIFO only drops when nothing leaves.
  assign push_req = hit & in_range & ~flush;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      hold_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // FSM next state; game_set_i overrides done pulses and pops
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pop        = 1'b0;
    if (game_set_i) begin
      state_d = StStop;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_d = StIssue;
            pop     = 1'b1;
          end
        end
        StIssue: state_d = StWait;
        StWait: begin
          if (done) begin
            if (HOLDOFF > 0) begin
              state_d    = StHold;
              hold_cnt_d = 4'd0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StHold: begin
          if (hold_cnt_q == HoldLast) begin
            state_d = StIdle;
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end
        StStop: state_d = StStop;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    dart_come_o = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      StIssue: begin
        dart_come_o = 1'b1;
        busy_o      = 1'b1;
      end
      StWait, StHold: busy_o = 1'b1;
      default: ;
    endcase
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {hit_x_i, hit_y_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      strobe_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
      pos_x_q    <= 4'd0;
      pos_y_q    <= 4'd0;
    end else begin
      strobe_q <= hit_strobe_i;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= 4'd0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q           <= rd_ptr_q + 1'b1;
          {pos_x_q, pos_y_q} <= mem_q[rd_ptr_q];
        end
        if (push && !pop) begin
          count_q <= count_q + 4'd1;
        end else if (pop && !push) begin
          count_q <= count_q - 4'd1;
        end
      end
    end
  end

  assign dart_position_x_o = pos_x_q;
  assign dart_position_y_o = pos_y_q;
  assign fifo_count_o      = count_q;
  assign overflow_o        = overflow_q;

endmodule

// File: tb/tb_dart_hit_capture.sv
module tb_dart_hit_capture;

  typedef struct {
    int         cyc;
    logic [3:0] x;
    logic [3:0] y;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  exp_t       q0[$];
  exp_t       qh[$];

  // DUT 0: default parameters
  logic       strobe, done1, done2, game_set;
  logic [3:0] hx, hy;
  logic       dart0, ovf0, busy0;
  logic [3:0] px0, py0, cnt0;
  // DUT H: HOLDOFF = 3
  logic       h_strobe, h_done;
  logic [3:0] h_x, h_y;
  logic       darth, ovfh, busyh;
  logic [3:0] pxh, pyh, cnth;
`ifdef DART_RANGE_CHECK_EN
  logic [7:0] drop0, droph;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dart_hit_capture u_dut (
    .clk               (clk),
    .reset             (reset),
    .hit_strobe_i      (strobe),
    .hit_x_i           (hx),
    .hit_y_i           (hy),
    .player_1_done_i   (done1),
    .player_2_done_i   (done2),
    .game_set_i        (game_set),
    .dart_come_o       (dart0),
    .dart_position_x_o (px0),
    .dart_position_y_o (py0),
    .fifo_count_o      (cnt0),
    .overflow_o        (ovf0),
`ifdef DART_RANGE_CHECK_EN
    .drop_count_o      (drop0),
`endif
    .busy_o            (busy0)
  );

  dart_hit_capture #(.FIFO_DEPTH(4), .HOLDOFF(3)) u_dut_h (
    .clk               (clk),
    .reset             (reset),
    .hit_strobe_i      (h_strobe),
    .hit_x_i           (h_x),
    .hit_y_i           (h_y),
    .player_1_done_i   (h_done),
    .player_2_done_i   (1'b0),
    .game_set_i        (1'b0),
    .dart_come_o       (darth),
    .dart_position_x_o (pxh),
    .dart_position_y_o (pyh),
    .fifo_count_o      (cnth),
    .overflow_o        (ovfh),
`ifdef DART_RANGE_CHECK_EN
    .drop_count_o      (droph),
`endif
    .busy_o            (busyh)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Inputs change 1 time unit after the edge that opens cycle k.
  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input int k);
    goto(k);
    @(negedge clk);
  endtask

  task automatic hit_pulse(input int c, input logic [3:0] x, input logic [3:0] y);
    goto(c);
    strobe = 1'b1; hx = x; hy = y;
    goto(c + 1);
    strobe = 1'b0;
  endtask

  task automatic done_pulse(input int c, input bit second);
    goto(c);
    if (second) done2 = 1'b1; else done1 = 1'b1;
    goto(c + 1);
    done1 = 1'b0; done2 = 1'b0;
  endtask

  // Scoreboard monitors: each dart_come_o pulse must match the next expected dart.
  always @(negedge clk) begin
    exp_t e;
    if (dart0 === 1'b1) begin
      if (q0.size() == 0) chk("dut0_unexpected_dart", 1, 0);
      else begin
        e = q0.pop_front();
        chk("dut0_dart_cycle", cyc, e.cyc);
        chk("dut0_dart_x", int'(px0), int'(e.x));
        chk("dut0_dart_y", int'(py0), int'(e.y));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (darth === 1'b1) begin
      if (qh.size() == 0) chk("duth_unexpected_dart", 1, 0);
      else begin
        e = qh.pop_front();
        chk("duth_dart_cycle", cyc, e.cyc);
        chk("duth_dart_x", int'(pxh), int'(e.x));
        chk("duth_dart_y", int'(pyh), int'(e.y));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; strobe = 1'b0; hx = '0; hy = '0;
    done1 = 1'b0; done2 = 1'b0; game_set = 1'b0;
    h_strobe = 1'b0; h_x = '0; h_y = '0; h_done = 1'b0;

    // Reset state
    sample(3);
    chk("reset_dart_come", int'(dart0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_count", int'(cnt0), 0);
    chk("reset_overflow", int'(ovf0), 0);
    chk("reset_pos_x", int'(px0), 0);
    chk("reset_pos_y", int'(py0), 0);
    goto(5);
    reset = 1'b1;

    // First dart: edge at 10, strobe held high three cycles
    goto(10);
    strobe = 1'b1; hx = 4'd3; hy = 4'd7;
    q0.push_back('{12, 4'd3, 4'd7});
    sample(11);
    chk("first_count_buffered", int'(cnt0), 1);
    chk("first_busy_idle", int'(busy0), 0);
    sample(12);
    chk("first_busy_issue", int'(busy0), 1);
    chk("first_count_popped", int'(cnt0), 0);
    goto(13);
    strobe = 1'b0;
    sample(14);
    chk("held_level_single_push", int'(cnt0), 0);
    done_pulse(15, 1'b1);
    sample(16);
    chk("done_returns_idle", int'(busy0), 0);

    // Done pulses in IDLE and ISSUE are ignored; three hits queue while waiting
    done_pulse(20, 1'b0);
    hit_pulse(22, 4'd1, 4'd2);
    q0.push_back('{24, 4'd1, 4'd2});
    done_pulse(24, 1'b0);
    hit_pulse(26, 4'd4, 4'd5);
    hit_pulse(28, 4'd6, 4'd8);
    hit_pulse(30, 4'd9, 4'd0);
    sample(31);
    chk("wait_count_three", int'(cnt0), 3);
    chk("wait_busy", int'(busy0), 1);
    done_pulse(34, 1'b0);
    q0.push_back('{36, 4'd4, 4'd5});
    sample(36);
    chk("count_after_pop", int'(cnt0), 2);
    done_pulse(38, 1'b1);
    q0.push_back('{40, 4'd6, 4'd8});
    done_pulse(42, 1'b0);
    q0.push_back('{44, 4'd9, 4'd0});
    done_pulse(46, 1'b0);
    sample(48);
    chk("drained_busy", int'(busy0), 0);
    chk("drained_count", int'(cnt0), 0);

    // Overflow: six hits, one issued, four buffered, sixth dropped
    hit_pulse(50, 4'd1, 4'd1);
    q0.push_back('{52, 4'd1, 4'd1});
    hit_pulse(52, 4'd2, 4'd2);
    hit_pulse(54, 4'd3, 4'd3);
    hit_pulse(56, 4'd4, 4'd4);
    hit_pulse(58, 4'd5, 4'd5);
    sample(59);
    chk("full_count", int'(cnt0), 4);
    chk("full_no_overflow_yet", int'(ovf0), 0);
    hit_pulse(60, 4'd6, 4'd6);
    sample(61);
    chk("overflow_set", int'(ovf0), 1);
    chk("overflow_count_capped", int'(cnt0), 4);
    // Push and pop together while full: nothing lost
    done_pulse(62, 1'b0);
    q0.push_back('{64, 4'd2, 4'd2});
    hit_pulse(63, 4'd7, 4'd7);
    sample(64);
    chk("full_push_pop_count", int'(cnt0), 4);
    done_pulse(66, 1'b0);
    q0.push_back('{68, 4'd3, 4'd3});
    done_pulse(70, 1'b0);
    q0.push_back('{72, 4'd4, 4'd4});
    sample(73);
    chk("pre_stop_count", int'(cnt0), 2);

    // game_set_i beats a simultaneous done pulse; STOP until reset
    goto(74);
    game_set = 1'b1; done1 = 1'b1;
    goto(75);
    game_set = 1'b0; done1 = 1'b0;
    sample(75);
    chk("stop_flushed", int'(cnt0), 0);
    chk("stop_busy", int'(busy0), 0);
    chk("overflow_sticky", int'(ovf0), 1);
    hit_pulse(80, 4'd1, 4'd1);
    done_pulse(85, 1'b0);
    done_pulse(90, 1'b1);
    sample(125);
    chk("stop_count_after_hits", int'(cnt0), 0);
    chk("stop_busy_late", int'(busy0), 0);

    // Reset with strobe held high: hit in first cycle after release
    goto(128);
    reset = 1'b0; strobe = 1'b1; hx = 4'd8; hy = 4'd9;
    goto(130);
    reset = 1'b1;
    q0.push_back('{132, 4'd8, 4'd9});
    sample(130);
    chk("post_reset_overflow", int'(ovf0), 0);
    chk("post_reset_pos_x", int'(px0), 0);
    chk("post_reset_busy", int'(busy0), 0);
    sample(131);
    chk("post_reset_count", int'(cnt0), 1);
    goto(133);
    strobe = 1'b0;
    done_pulse(134, 1'b0);

    // Out-of-range coordinates
    hit_pulse(137, 4'd12, 4'd4);
`ifdef DART_RANGE_CHECK_EN
    sample(138);
    chk("range_no_push", int'(cnt0), 0);
    chk("range_drop_count", int'(drop0), 1);
`else
    q0.push_back('{139, 4'd12, 4'd4});
    done_pulse(141, 1'b0);
`endif
    sample(145);
    chk("range_idle", int'(busy0), 0);

    // HOLDOFF = 3: done at 155 -> HOLD 156..158, dart at 160
    goto(150);
    h_strobe = 1'b1; h_x = 4'd2; h_y = 4'd3;
    qh.push_back('{152, 4'd2, 4'd3});
    goto(151);
    h_strobe = 1'b0;
    goto(153);
    h_strobe = 1'b1; h_x = 4'd5; h_y = 4'd6;
    goto(154);
    h_strobe = 1'b0;
    goto(155);
    h_done = 1'b1;
    qh.push_back('{160, 4'd5, 4'd6});
    goto(156);
    h_done = 1'b0;
    sample(157);
    chk("hold_busy", int'(busyh), 1);
    chk("hold_count", int'(cnth), 1);
    goto(163);
    h_done = 1'b1;
    goto(164);
    h_done = 1'b0;
    sample(166);
    chk("hold_busy_late", int'(busyh), 1);
    sample(168);
    chk("hold_done_idle", int'(busyh), 0);

    sample(175);
    chk("dut0_darts_outstanding", q0.size(), 0);
    chk("duth_darts_outstanding", qh.size(), 0);
    chk("duth_overflow", int'(ovfh), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dart_hit_capture.md
DART_HIT_CAPTURE -- requirements
Module: dart_hit_capture

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of buffered hits (power of two, 2..8).
REQ-002 Parameter: HOLDOFF, 0, idle cycles inserted after a done pulse before the next issue (0..15).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 hit_strobe_i  input  1  raw level strobe from impact sensor; a hit is its rising edge.
REQ-006 hit_x_i, hit_y_i  input  4 each  sensor coordinates, valid in the rising-edge cycle.
REQ-007 player_1_done_i, player_2_done_i  input  1 each  one-cycle turn-end pulses from the scoring machine.
REQ-008 game_set_i  input  1  game-over indication from the scoring machine.
REQ-009 dart_come_o  output  1  one-cycle dart-arrival pulse to the scoring machine.
REQ-010 dart_position_x_o, dart_position_y_o  output  4 each  coordinates of the issued dart.
REQ-011 fifo_count_o  output  4  current FIFO occupancy.
REQ-012 overflow_o  output  1  sticky: a hit was lost to a full FIFO.
REQ-013 busy_o  output  1  high while a dart is outstanding (ISSUE, WAIT, HOLD).

Function
REQ-014 Edge detect: a hit is accepted in cycle N when hit_strobe_i=1 in N and 0 in N-1 (previous-sample register resets to 0).
REQ-015 Accepted hit {x,y} pushed into FIFO at end of cycle N; level held high produces exactly one push.
REQ-016 FSM states: IDLE, ISSUE, WAIT, HOLD, STOP.
REQ-017 IDLE: FIFO non-empty -> ISSUE; head popped, head x/y loaded into position output registers on that transition.
REQ-018 ISSUE: dart_come_o=1 for exactly this one cycle; -> WAIT unconditionally.
REQ-019 WAIT: player_1_done_i or player_2_done_i -> HOLD if HOLDOFF>0, else IDLE; otherwise stay.
REQ-020 HOLD: counts HOLDOFF cycles, then -> IDLE.
REQ-021 dart_position_x_o/y_o stay constant from the ISSUE cycle until the next ISSUE load.
REQ-022 Latency: empty FIFO, FSM in IDLE, edge in cycle N -> dart_come_o high in cycle N+2.
REQ-023 Done pulses outside WAIT are ignored.
REQ-024 Full FIFO and push with no pop in same cycle: hit dropped, overflow_o set; push and pop in same cycle when full: both performed, no drop.
REQ-025 Pointers wrap modulo FIFO_DEPTH; fifo_count_o never exceeds FIFO_DEPTH.
REQ-026 game_set_i=1 in any state: next state STOP, FIFO flushed (count 0), no further dart_come_o; STOP exits only by reset.
REQ-027 game_set_i takes priority over done pulses and pops in the same cycle.

Reset
REQ-028 reset=0 at a clock edge: FSM IDLE, FIFO empty, dart_come_o=0, positions 0, fifo_count_o=0, overflow_o=0, busy_o=0, HOLD counter 0, edge register 0.
REQ-029 Reset mid-operation discards outstanding dart and buffered hits; a strobe held high across reset release produces a hit in the first cycle after release.

Configuration
REQ-030 Macro DART_RANGE_CHECK_EN defined: hits with x>9 or y>9 are not pushed and increment drop_count_o (output, 8 bits, saturating at 255, reset 0).
REQ-031 Macro DART_RANGE_CHECK_EN undefined: all hits pushed unchanged; drop_count_o port absent.

Verification
REQ-032 Reset, strobe 0->1 at cycle 10 with x=3,y=7 -> dart_come_o high cycle 12 only, positions 3/7, busy_o high from 12.
REQ-033 Three hits while WAIT, then player_1_done_i pulse, HOLDOFF=0 -> next dart_come_o two cycles after the done pulse (HOLD bypassed via IDLE), fifo_count_o 3->2.
REQ-034 Six hits with no done pulse, FIFO_DEPTH=4 -> one issued, four buffered, sixth hit dropped, overflow_o=1 and stays 1.
REQ-035 game_set_i pulse with count 2 while WAIT -> STOP next cycle, fifo_count_o=0, no dart_come_o for 50 cycles; reset -> IDLE.
REQ-036 DART_RANGE_CHECK_EN defined, hit x=12,y=4 -> no push, drop_count_o=1; undefined -> dart issued with x=12.
REQ-037 HOLDOFF=3, hit buffered, done pulse at cycle T -> HOLD three cycles, dart_come_o at T+5.
